// File: rtl/change_dispenser.sv
// Payout back-end for the vending machine: queues sale events and drives the product motor and
// the 5/10-unit coin hoppers through req/ack handshakes, tracking hopper inventory and faults.
module change_dispenser #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             out,
    input  logic [1:0]       change,
    input  logic             load5,
    input  logic             load10,
    input  logic [CNT_W-1:0] load_cnt,
    output logic             prod_req,
    input  logic             prod_ack,
    output logic             hop5_req,
    output logic             hop10_req,
    input  logic             hop5_ack,
    input  logic             hop10_ack,
    output logic             busy,
    output logic             shortage,
    output logic             fault,
    output logic             overflow,
    output logic [CNT_W-1:0] inv5,
    output logic [CNT_W-1:0] inv10
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PROD = 3'd1,
        S_C10  = 3'd2,
        S_C5A  = 3'd3,
        S_C5B  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // Sale queue: each entry is {out, change}
    logic [2:0]       q_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             q_empty, q_full, ev_valid, push, pop, ovf_set;
    logic [2:0]       head;

    logic [1:0]       entry_reg, entry_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             prod_req_reg, hop5_req_reg, hop10_req_reg;
    logic             prod_req_next, hop5_req_next, hop10_req_next;
    logic             shortage_reg, fault_reg, overflow_reg;
    logic [CNT_W-1:0] inv5_reg, inv10_reg;

    logic             cur_req, cur_ack, ack_hit, tmo_hit;
    logic             dec5, dec10, shortage_set;
    logic [1:0]       code_sel;
    state_t           res_state;
    logic             res_short;

    assign q_empty  = (count_reg == '0);
    assign q_full   = (count_reg == DEPTH_C);
    assign ev_valid = out | (change == 2'b01) | (change == 2'b10);
    assign pop      = (state_reg == S_IDLE) && !q_empty;
    assign push     = ev_valid && (!q_full || pop);
    assign ovf_set  = ev_valid && q_full && !pop;
    assign head     = q_mem[rd_ptr_reg];
    assign count_next = count_reg + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_reg] <= {out, change};
        end
    end

    // Remaining inventory after a possible coin ejection plus a possible refill, clamped at full scale
    function automatic logic [CNT_W-1:0] inv_update(input logic [CNT_W-1:0] cur, input logic dec,
                                                     input logic ld, input logic [CNT_W-1:0] amt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} - (CNT_W + 1)'(dec) + (ld ? {1'b0, amt} : '0);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        cur_req = 1'b0;
        cur_ack = 1'b0;
        case (state_reg)
            S_PROD:       begin cur_req = prod_req_reg;  cur_ack = prod_ack;  end
            S_C10:        begin cur_req = hop10_req_reg; cur_ack = hop10_ack; end
            S_C5A, S_C5B: begin cur_req = hop5_req_reg;  cur_ack = hop5_ack;  end
            default:      begin cur_req = 1'b0;          cur_ack = 1'b0;      end
        endcase
    end

    assign ack_hit = cur_req && cur_ack;
    assign tmo_hit = cur_req && !cur_ack && (tmo_cnt_reg == TMO_LAST);

    // Change resolution, shared by the IDLE pop path and the post-product path
    assign code_sel = (state_reg == S_IDLE) ? head[1:0] : entry_reg;

    always_comb begin
        res_state = S_IDLE;
        res_short = 1'b0;
        case (code_sel)
            2'b01: begin
                if (inv5_reg != '0) res_state = S_C5B;
                else                res_short = 1'b1;
            end
            2'b10: begin
                if (inv10_reg != '0)              res_state = S_C10;
                else if (inv5_reg >= CNT_W'(2))   res_state = S_C5A;
                else                              res_short = 1'b1;
            end
            default: begin
                res_state = S_IDLE;
                res_short = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            entry_reg     <= '0;
            tmo_cnt_reg   <= '0;
            prod_req_reg  <= 1'b0;
            hop5_req_reg  <= 1'b0;
            hop10_req_reg <= 1'b0;
            shortage_reg  <= 1'b0;
            fault_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            inv5_reg      <= '0;
            inv10_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_reg + PTR_W'(push);
            rd_ptr_reg    <= rd_ptr_reg + PTR_W'(pop);
            count_reg     <= count_next;
            entry_reg     <= entry_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            prod_req_reg  <= prod_req_next;
            hop5_req_reg  <= hop5_req_next;
            hop10_req_reg <= hop10_req_next;
            shortage_reg  <= shortage_reg | shortage_set;
            fault_reg     <= fault_reg | tmo_hit;
            overflow_reg  <= overflow_reg | ovf_set;
            inv5_reg      <= inv_update(inv5_reg, dec5, load5, load_cnt);
            inv10_reg     <= inv_update(inv10_reg, dec10, load10, load_cnt);
        end
    end

    always_comb begin
        state_next   = state_reg;
        entry_next   = entry_reg;
        shortage_set = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!q_empty) begin
                    entry_next = head[1:0];
                    if (head[2]) begin
                        state_next = S_PROD;
                    end else begin
                        state_next   = res_state;
                        shortage_set = res_short;
                    end
                end
            end
            S_PROD: begin
                if (ack_hit) begin
                    state_next   = res_state;
                    shortage_set = res_short;
                end else if (tmo_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_C5A: begin
                if (ack_hit)      state_next = S_C5B;
                else if (tmo_hit) state_next = S_IDLE;
            end
            S_C10, S_C5B: begin
                if (ack_hit || tmo_hit) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Requests rise one cycle after state entry, so adjacent handshakes always see a low cycle
    always_comb begin
        prod_req_next  = (state_reg == S_PROD) && !ack_hit && !tmo_hit;
        hop10_req_next = (state_reg == S_C10) && !ack_hit && !tmo_hit;
        hop5_req_next  = ((state_reg == S_C5A) || (state_reg == S_C5B)) && !ack_hit && !tmo_hit;
        dec5           = ack_hit && ((state_reg == S_C5A) || (state_reg == S_C5B));
        dec10          = ack_hit && (state_reg == S_C10);
        if ((state_reg == S_IDLE) || ack_hit || tmo_hit) begin
            tmo_cnt_next = '0;
        end else if (cur_req) begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end else begin
            tmo_cnt_next = tmo_cnt_reg;
        end
    end

    assign prod_req  = prod_req_reg;
    assign hop5_req  = hop5_req_reg;
    assign hop10_req = hop10_req_reg;
    assign busy      = !q_empty || (state_reg != S_IDLE);
    assign shortage  = shortage_reg;
    assign fault     = fault_reg;
    assign overflow  = overflow_reg;
    assign inv5      = inv5_reg;
    assign inv10     = inv10_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected request order is queued at stimulus time
// and popped as each request rises; inventories and flags come from a small bench model.
module tb_change_dispenser;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 4;

    logic             clk = 1'b0;
    logic             rst, out, load5, load10;
    logic [1:0]       change;
    logic [CNT_W-1:0] load_cnt;
    logic             prod_req, hop5_req, hop10_req;
    logic             prod_ack, hop5_ack, hop10_ack;
    logic             busy, shortage, fault, overflow;
    logic [CNT_W-1:0] inv5, inv10;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int inv5_m = 0;
    int inv10_m = 0;
    int sh_m = 0;
    logic prod_en = 1'b1, hop5_en = 1'b1, hop10_en = 1'b1;
    logic p_prev = 1'b0, h5_prev = 1'b0, h10_prev = 1'b0;

    change_dispenser #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .out(out), .change(change),
        .load5(load5), .load10(load10), .load_cnt(load_cnt),
        .prod_req(prod_req), .prod_ack(prod_ack),
        .hop5_req(hop5_req), .hop10_req(hop10_req),
        .hop5_ack(hop5_ack), .hop10_ack(hop10_ack),
        .busy(busy), .shortage(shortage), .fault(fault), .overflow(overflow),
        .inv5(inv5), .inv10(inv10)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ack responder: answers each enabled request in the cycle it first appears
    initial forever begin
        @(negedge clk);
        prod_ack  = prod_req & prod_en;
        hop5_ack  = hop5_req & hop5_en;
        hop10_ack = hop10_req & hop10_en;
    end

    // Request monitor: 0 = product, 1 = hop5, 2 = hop10
    initial forever begin
        @(negedge clk);
        if ((prod_req && !p_prev) || (hop5_req && !h5_prev) || (hop10_req && !h10_prev)) begin
            int obs;
            obs = (prod_req && !p_prev) ? 0 : (hop5_req && !h5_prev) ? 1 : 2;
            $display("req rise type=%0d t=%0t", obs, $time);
            check("one_req_high", 32'(prod_req) + 32'(hop5_req) + 32'(hop10_req), 1);
            if (exp_q.size() == 0) check("req_order_unexpected", obs, 32'hFFFF_FFFF);
            else                   check("req_order", obs, exp_q.pop_front());
        end
        p_prev   = prod_req;
        h5_prev  = hop5_req;
        h10_prev = hop10_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_load(input bit ten, input int n);
        load_cnt = CNT_W'(n);
        if (ten) begin load10 = 1'b1; inv10_m = (inv10_m + n > 255) ? 255 : inv10_m + n; end
        else     begin load5  = 1'b1; inv5_m  = (inv5_m  + n > 255) ? 255 : inv5_m  + n; end
        @(negedge clk);
        load5 = 1'b0; load10 = 1'b0; load_cnt = '0;
        $display("load ten=%0d n=%0d inv5=%0d inv10=%0d", ten, n, inv5, inv10);
    endtask

    task automatic drive_event(input logic o, input logic [1:0] c);
        if (o) exp_q.push_back(0);
        if (c == 2'b01) begin
            if (inv5_m >= 1) begin exp_q.push_back(1); inv5_m--; end
            else sh_m = 1;
        end else if (c == 2'b10) begin
            if (inv10_m >= 1)     begin exp_q.push_back(2); inv10_m--; end
            else if (inv5_m >= 2) begin exp_q.push_back(1); exp_q.push_back(1); inv5_m -= 2; end
            else sh_m = 1;
        end
        out = o; change = c;
        $display("event out=%0d change=%0d", o, c);
    endtask

    task automatic send(input logic o, input logic [1:0] c);
        drive_event(o, c);
        @(negedge clk);
        out = 1'b0; change = 2'b00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        check("busy_low_when_done", 32'(busy), 0);
        check("pending_reqs", exp_q.size(), 0);
    endtask

    initial begin
        int n, hi;
        rst = 1'b1; out = 1'b0; change = 2'b00; load5 = 1'b0; load10 = 1'b0; load_cnt = '0;
        prod_ack = 1'b0; hop5_ack = 1'b0; hop10_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_prod_req", 32'(prod_req), 0);
        check("rst_hop5_req", 32'(hop5_req), 0);
        check("rst_hop10_req", 32'(hop10_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", {29'd0, shortage, fault, overflow}, 0);
        check("rst_inv5", 32'(inv5), 0);
        check("rst_inv10", 32'(inv10), 0);

        // Product plus 10-coin, with latency checks
        do_load(1'b0, 3);
        do_load(1'b1, 1);
        check("load_inv5", 32'(inv5), inv5_m);
        check("load_inv10", 32'(inv10), inv10_m);
        drive_event(1'b1, 2'b10);
        @(negedge clk);
        out = 1'b0; change = 2'b00;
        check("busy_after_event", 32'(busy), 1);
        @(negedge clk);
        check("prod_req_latency_t1", 32'(prod_req), 0);
        @(negedge clk);
        check("prod_req_latency_t2", 32'(prod_req), 1);
        wait_idle();
        check("s1_inv10", 32'(inv10), inv10_m);
        check("s1_inv5", 32'(inv5), inv5_m);
        check("s1_shortage", 32'(shortage), sh_m);

        // 10 paid as two 5-coins
        send(1'b0, 2'b01);
        wait_idle();
        send(1'b0, 2'b10);
        wait_idle();
        check("s2_inv5", 32'(inv5), inv5_m);
        check("s2_shortage", 32'(shortage), sh_m);

        // Shortage with no partial payout, then a 5-coin still pays
        do_load(1'b0, 1);
        send(1'b0, 2'b10);
        wait_idle();
        check("s3_shortage", 32'(shortage), sh_m);
        check("s3_inv5_kept", 32'(inv5), inv5_m);
        send(1'b0, 2'b01);
        wait_idle();
        check("s3_inv5_paid", 32'(inv5), inv5_m);

        // hop5 timeout, next entry still serviced
        do_load(1'b0, 2);
        do_load(1'b1, 1);
        hop5_en = 1'b0;
        send(1'b0, 2'b01);
        inv5_m++;
        send(1'b0, 2'b10);
        n = 0;
        while (hop5_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        hi = 0;
        while (hop5_req === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
        check("timeout_req_cycles", hi, TIMEOUT);
        hop5_en = 1'b1;
        check("timeout_fault", 32'(fault), 1);
        wait_idle();
        check("timeout_inv5", 32'(inv5), inv5_m);
        check("timeout_inv10", 32'(inv10), inv10_m);

        // Queue fill and overflow with product ack withheld, then reset mid-PROD
        prod_en = 1'b0;
        exp_q.push_back(0);
        for (int i = 0; i < 5; i++) begin
            out = 1'b1; change = 2'b00;
            @(negedge clk);
        end
        out = 1'b0;
        check("no_overflow_at_full", 32'(overflow), 0);
        out = 1'b1;
        @(negedge clk);
        out = 1'b0;
        check("overflow_set", 32'(overflow), 1);
        check("prod_req_mid", 32'(prod_req), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_reqs", {29'd0, prod_req, hop5_req, hop10_req}, 0);
        check("rst2_busy", 32'(busy), 0);
        check("rst2_flags", {29'd0, shortage, fault, overflow}, 0);
        check("rst2_inv", {16'd0, inv5, inv10}, 0);
        exp_q.delete();
        inv5_m = 0; inv10_m = 0; sh_m = 0;
        prod_en = 1'b1;
        @(negedge clk);
        check("rst2_idle_after", 32'(busy), 0);

        // Load coinciding with a hop5 ack saturates
        do_load(1'b0, 10);
        check("s6_inv5_loaded", 32'(inv5), inv5_m);
        send(1'b0, 2'b01);
        n = 0;
        while (hop5_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        load5 = 1'b1; load_cnt = 8'd255;
        @(negedge clk);
        load5 = 1'b0; load_cnt = '0;
        inv5_m = 255;
        check("s6_hop5_dropped", 32'(hop5_req), 0);
        check("s6_inv5_sat", 32'(inv5), inv5_m);
        wait_idle();
        do_load(1'b1, 200);
        do_load(1'b1, 200);
        check("inv10_load_sat", 32'(inv10), inv10_m);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Back-end payout controller for the vending machine. It consumes the machine's product-release strobe and change code, queues each sale, and drives the product motor and two coin hoppers (5-unit and 10-unit) with request/acknowledge handshakes. It tracks hopper inventory and substitutes two 5-unit coins when the 10-unit hopper is empty. It flags hopper timeouts and coin shortages.

## Interface
- CNT_W, 8, width of each hopper inventory counter
- TIMEOUT, 16, cycles to wait for an ack before declaring a fault (≥2)
- DEPTH, 4, sale-event queue depth (power of two)

- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- out  input  1  product-release strobe from vending_machine, sampled every cycle
- change  input  2  change code from vending_machine: 00 none, 01 five, 10 ten, 11 reserved (treated as none)
- load5  input  1  add load_cnt coins to the 5-unit inventory
- load10  input  1  add load_cnt coins to the 10-unit inventory
- load_cnt  input  CNT_W  refill amount
- prod_req  output  1  product motor request
- prod_ack  input  1  product delivered
- hop5_req / hop10_req  output  1  eject one coin from that hopper
- hop5_ack / hop10_ack  input  1  coin ejected
- busy  output  1  queue non-empty or FSM not IDLE
- shortage  output  1  sticky: change owed could not be paid
- fault  output  1  sticky: an ack timed out
- overflow  output  1  sticky: an event was dropped on a full queue
- inv5 / inv10  output  CNT_W  current inventories

## Operation
- Event: any cycle with out=1 or change∈{01,10}. It is pushed as {out, change} into the queue. If the queue is full, the event is dropped and overflow is set.
- FSM states: IDLE, PROD, C10, C5A, C5B.
- IDLE: if the queue is non-empty, pop one entry.
  - With out=1, go to PROD.
  - Otherwise, resolve the change (rules below).
  - An entry with out=0 and change=00/11 is discarded.
- Change resolution:
  - 01: if inv5≥1, go to C5B; else set shortage and go to IDLE.
  - 10: if inv10≥1, go to C10; else if inv5≥2, go to C5A; else set shortage and go to IDLE. There is no partial payout.
- PROD: after ack, resolve the change of the current entry.
- C10, C5A, C5B: assert the matching req.
  - On ack: drop req, decrement the inventory by 1.
  - Next state: C5A→C5B; C10/C5B→IDLE.
- Ack handling:
  - Acks are honoured only while the matching req is high; stray acks are ignored.
  - Each request state has a timeout counter, cleared on state entry. When it reaches TIMEOUT with no ack: set fault, drop req, abandon the rest of the entry, go to IDLE. The inventory is not decremented.
- Inventory:
  - Loads saturate at 2^CNT_W−1.
  - A load and a decrement in the same cycle apply both: (inv − 1 + load_cnt), saturated.
- Sticky flags clear only on rst.

## Timing
- Reset values: all reqs 0, busy 0, shortage/fault/overflow 0, inv5=inv10=0, queue empty, state IDLE.
- Reset mid-handshake drops the req on the next cycle and flushes the queue.
- Latency, with the queue empty and state IDLE:
  - Event sampled at edge t.
  - Popped at edge t+1.
  - req high from edge t+2.
- Handshake:
  - req is registered and held high until the cycle ack is sampled high.
  - req is low the following cycle; at most one req is high at any time.
  - The next req rises no earlier than one cycle after the previous one falls.
- Ack on the cycle req first rises is accepted: minimum request duration is 1 cycle.
- Queue:
  - Simultaneous push and pop when full succeeds; no overflow.
  - Push into an empty queue is not visible to the pop in the same cycle.
- busy goes high the cycle after an event is accepted. It goes low the cycle after the FSM returns to IDLE with the queue empty.

## Test plan
- inv5=3, inv10=1; event out=1, change=10; acks 1 cycle after each req → prod_req, then hop10_req; inv10=0, inv5=3; busy low afterward.
- inv10=0, inv5=2; change=10 → two hop5_req pulses separated by ≥1 low cycle; inv5=0; shortage=0.
- inv5=1, inv10=0; change=10 → no hopper req; shortage=1; inv5 stays 1; a later change=01 still pays one 5-coin.
- hop5_ack withheld → hop5_req high exactly TIMEOUT cycles, then low; fault=1; inv5 unchanged; next queued entry still serviced.
- Five back-to-back events with prod_ack withheld (DEPTH=4) → first popped, four queued, no overflow; a sixth event sets overflow=1; assert rst mid-PROD → all outputs return to reset values next cycle.
- load5 with load_cnt=255 on inv5=10, simultaneous with a hop5 ack → inv5=255 (saturated).
